// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encodings: ALU op and instruction-class enums, opcodes, funct codes.
// Used by both the decode path and instr_encoder so the two sides always agree.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_R_ALU  = 3'd0,
        CLS_I_ALU  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } instr_class_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_OP    = 2'd1,
        ERR_IMM   = 2'd2,
        ERR_CLASS = 2'd3
    } err_code_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Symbolic request as presented on the request port.
    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } enc_req_t;

    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        case (op)
            4'(ALU_SLL):  alu_funct3 = F3_SLL;
            4'(ALU_SLT):  alu_funct3 = F3_SLT;
            4'(ALU_SLTU): alu_funct3 = F3_SLTU;
            4'(ALU_XOR):  alu_funct3 = F3_XOR;
            4'(ALU_SRL),
            4'(ALU_SRA):  alu_funct3 = F3_SR;
            4'(ALU_OR):   alu_funct3 = F3_OR;
            4'(ALU_AND):  alu_funct3 = F3_AND;
            default:      alu_funct3 = F3_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_field_enc.sv
// Combinational field encoder: symbolic request -> 32-bit RV32I word, legality and
// first-class error cause (class checked first, then op, then immediate).
module instr_field_enc
    import instr_encoder_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] word,
    output logic        legal,
    output logic [1:0]  err_code
);

    logic       op_known;
    logic       is_shift;
    logic       is_alt;
    logic [2:0] f3;

    always_comb begin
        word     = '0;
        err_code = ERR_NONE;
        op_known = (req.op <= 4'(ALU_AND));
        is_shift = (req.op == 4'(ALU_SLL)) || (req.op == 4'(ALU_SRL)) || (req.op == 4'(ALU_SRA));
        is_alt   = (req.op == 4'(ALU_SUB)) || (req.op == 4'(ALU_SRA));
        f3       = alu_funct3(req.op);

        case (req.cls)
            3'(CLS_R_ALU): begin
                if (!op_known) err_code = ERR_OP;
                else word = {(is_alt ? F7_ALT : F7_BASE), req.rs2, req.rs1, f3, req.rd, OP_R};
            end
            3'(CLS_I_ALU): begin
                if (!op_known || req.op == 4'(ALU_SUB)) err_code = ERR_OP;
                else if (is_shift && req.imm[11:5] != 7'd0) err_code = ERR_IMM;
                // Shifts carry shamt in imm[4:0]; funct7 is inserted here, not by the caller.
                else if (is_shift)
                    word = {(is_alt ? F7_ALT : F7_BASE), req.imm[4:0], req.rs1, f3, req.rd, OP_I};
                else
                    word = {req.imm[11:0], req.rs1, f3, req.rd, OP_I};
            end
            3'(CLS_LOAD): begin
                if (req.op != 4'(ALU_ADD)) err_code = ERR_OP;
                else word = {req.imm[11:0], req.rs1, F3_LW, req.rd, OP_LOAD};
            end
            3'(CLS_STORE): begin
                if (req.op != 4'(ALU_ADD)) err_code = ERR_OP;
                else word = {req.imm[11:5], req.rs2, req.rs1, F3_SW, req.imm[4:0], OP_STORE};
            end
            3'(CLS_BRANCH): begin
                if (req.op != 4'(ALU_SUB)) err_code = ERR_OP;
                else if (req.imm[0]) err_code = ERR_IMM;
                else word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                             req.imm[4:1], req.imm[11], OP_BRANCH};
            end
            default: err_code = ERR_CLASS;
        endcase

        legal = (err_code == ERR_NONE);
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder/loader: accepts symbolic requests and writes encoded words
// to consecutive imem addresses. Optional err_cnt output under INSTR_ENC_ERR_CNT_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [3:0]        req_alu_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              done,
    output logic              err,
`ifdef INSTR_ENC_ERR_CNT_EN
    output logic [15:0]       err_cnt,
`endif
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_q;
    enc_req_t          enc_req;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [1:0]        enc_err;
    logic              accept;

    assign enc_req = '{cls: req_class, op: req_alu_op, rd: req_rd,
                       rs1: req_rs1, rs2: req_rs2, imm: req_imm};

    instr_field_enc u_field_enc (
        .req      (enc_req),
        .word     (enc_word),
        .legal    (enc_legal),
        .err_code (enc_err)
    );

    // Combinational so that a same-cycle clr wins over req_valid.
    assign req_ready = !rst && !clr && (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= BASE;
            last_q     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else if (clr) begin
            state      <= S_IDLE;
            cnt        <= BASE;
            last_q     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (enc_legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= cnt;
                            imem_wdata <= enc_word;
                            last_q     <= req_last;
                            state      <= S_WRITE;
                        end else begin
                            // err_code keeps the first cause until rst/clr.
                            err <= 1'b1;
                            if (!err) err_code <= enc_err;
                            if (req_last) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_ready) begin
                        imem_we <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    cnt   <= BASE;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef INSTR_ENC_ERR_CNT_EN
    // Saturating count of rejected requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (accept && !enc_legal && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=2 so address wrap is reachable quickly).
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_class;
    logic [3:0]  req_alu_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [12:0] req_imm;
    logic        req_last;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
`ifdef INSTR_ENC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_alu_op (req_alu_op),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .done       (done),
        .err        (err),
`ifdef INSTR_ENC_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .err_code   (err_code)
    );

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completing write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && imem_we === 1'b1 && imem_ready === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic drop_exp();
        exp_t e;
        if (q.size() != 0) e = q.pop_front();
    endtask

    // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [2:0] cls, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [12:0] imm, input logic last);
        int n;
        req_valid  = 1'b1;
        req_class  = cls;
        req_alu_op = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_last   = last;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (req_ready !== 1'b1) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 8);
        chk({name, "_done_high"}, 32'(done), 32'd1);
        chk({name, "_ready_in_done"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic chk_err(input string name, input logic [1:0] code);
        chk({name, "_err"}, 32'(err), 32'd1);
        chk({name, "_err_code"}, 32'(err_code), 32'(code));
        chk({name, "_no_we"}, 32'(imem_we), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_class = '0; req_alu_op = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_last = 1'b0;
        imem_ready = 1'b1;
        step(2);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        step(1);

        // R-type, then I-type; fifth legal write wraps the 2-bit address to 0.
        expect_wr(2'd0, 32'h002081B3);
        send(3'(CLS_R_ALU), 4'(ALU_ADD), 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("radd_we_n1", 32'(imem_we), 32'd1);
        chk("radd_ready_low", 32'(req_ready), 32'd0);
        expect_wr(2'd1, 32'h407302B3);
        send(3'(CLS_R_ALU), 4'(ALU_SUB), 5'd5, 5'd6, 5'd7, 13'd0, 1'b0);
        expect_wr(2'd2, 32'hFFF00093);
        send(3'(CLS_I_ALU), 4'(ALU_ADD), 5'd1, 5'd0, 5'd9, 13'h1FFF, 1'b0);
        expect_wr(2'd3, 32'h40325213);
        send(3'(CLS_I_ALU), 4'(ALU_SRA), 5'd4, 5'd4, 5'd0, 13'd3, 1'b0);
        send(3'(CLS_I_ALU), 4'(ALU_SRL), 5'd1, 5'd1, 5'd0, 13'h23, 1'b0);
        chk_err("srl_bad_imm", 2'd2);
        chk("srl_ready", 32'(req_ready), 32'd1);

        // Store held under backpressure for 3 cycles.
        imem_ready = 1'b0;
        expect_wr(2'd0, 32'h0020A423);
        send(3'(CLS_STORE), 4'(ALU_ADD), 5'd0, 5'd1, 5'd2, 13'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sw_hold_we", 32'(imem_we), 32'd1);
            chk("sw_hold_addr", 32'(imem_addr), 32'd0);
            chk("sw_hold_data", imem_wdata, 32'h0020A423);
            step(1);
        end
        imem_ready = 1'b1;
        step(1);
        chk("sw_we_drop", 32'(imem_we), 32'd0);

        // Last branch: written at addr 1, done pulse, then counter back to base.
        expect_wr(2'd1, 32'hFE208EE3);
        send(3'(CLS_BRANCH), 4'(ALU_SUB), 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1);
        wait_done("beq_last");
        chk("err_persists_done", 32'(err), 32'd1);
        expect_wr(2'd0, 32'h002081B3);
        send(3'(CLS_R_ALU), 4'(ALU_ADD), 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        step(1);

        // clr mid-WRITE abandons the write; clr also beats a same-cycle req_valid.
        imem_ready = 1'b0;
        expect_wr(2'd1, 32'h00412383);
        send(3'(CLS_LOAD), 4'(ALU_ADD), 5'd7, 5'd2, 5'd0, 13'd4, 1'b0);
        chk("lw_we", 32'(imem_we), 32'd1);
        chk("lw_addr", 32'(imem_addr), 32'd1);
        clr = 1'b1;
        req_valid = 1'b1;
        req_class = 3'(CLS_R_ALU); req_alu_op = 4'(ALU_OR);
        #1;
        chk("clr_ready_write", 32'(req_ready), 32'd0);
        step(1);
        chk("clr_ready_idle", 32'(req_ready), 32'd0);
        chk("clr_we", 32'(imem_we), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_err_code", 32'(err_code), 32'd0);
        chk("clr_addr", 32'(imem_addr), 32'd0);
        drop_exp();
        clr = 1'b0;
        req_valid = 1'b0;
        imem_ready = 1'b1;
        step(1);
        chk("clr_no_accept", 32'(imem_we), 32'd0);

        // Error causes; err_code keeps the first one.
        send(3'(CLS_BRANCH), 4'(ALU_SUB), 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
        chk_err("beq_odd_imm", 2'd2);
        send(3'(CLS_LOAD), 4'(ALU_SUB), 5'd1, 5'd1, 5'd0, 13'd0, 1'b0);
        chk_err("lw_sub_keeps", 2'd2);
`ifdef INSTR_ENC_ERR_CNT_EN
        chk("err_cnt_two", 32'(err_cnt), 32'd2);
`endif
        do_clr();
        send(3'(CLS_STORE), 4'(ALU_XOR), 5'd0, 5'd1, 5'd2, 13'd0, 1'b0);
        chk_err("sw_xor_op", 2'd1);
        do_clr();
        send(3'd7, 4'(ALU_ADD), 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
        chk_err("bad_class", 2'd3);
        send(3'(CLS_BRANCH), 4'(ALU_ADD), 5'd0, 5'd1, 5'd2, 13'd0, 1'b1);
        chk_err("illegal_last", 2'd3);
        wait_done("illegal_last");

        do_clr();
`ifdef INSTR_ENC_ERR_CNT_EN
        chk("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif
        send(3'(CLS_R_ALU), 4'hF, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
        send(3'd6, 4'(ALU_ADD), 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
        send(3'(CLS_BRANCH), 4'(ALU_SUB), 5'd0, 5'd1, 5'd2, 13'd1, 1'b0);
        chk_err("three_errs_first", 2'd1);
`ifdef INSTR_ENC_ERR_CNT_EN
        chk("err_cnt_three", 32'(err_cnt), 32'd3);
`endif

        // Async reset in the middle of a stalled write.
        imem_ready = 1'b0;
        expect_wr(2'd0, 32'h002081B3);
        send(3'(CLS_R_ALU), 4'(ALU_ADD), 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("pre_rst_we", 32'(imem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_err_code", 32'(err_code), 32'd0);
        drop_exp();
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;
        step(1);
        expect_wr(2'd0, 32'h00C5F533);
        send(3'(CLS_R_ALU), 4'(ALU_AND), 5'd10, 5'd11, 5'd12, 13'd0, 1'b0);
        step(2);
        chk("final_we", 32'(imem_we), 32'd0);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
